// File: rtl/stream_mux_rr_if.sv
// Handshake bundle between N producer streams, the mux and its single consumer.
// The master modport is the environment side and the slave modport is the mux.
interface stream_mux_rr_if #(
    parameter int unsigned N_CH  = 4,
    parameter int unsigned WIDTH = 8,
    parameter int unsigned SEL_W = (N_CH > 1) ? $clog2(N_CH) : 1
);
    logic                    mode;
    logic [SEL_W-1:0]        sel;
    logic [N_CH-1:0]         in_valid;
    logic [N_CH-1:0]         in_ready;
    logic [N_CH*WIDTH-1:0]   in_data;
    logic                    out_valid;
    logic                    out_ready;
    logic [WIDTH-1:0]        out_data;
    logic [SEL_W-1:0]        out_ch;

    modport master (
        output mode, sel, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_ch
    );

    modport slave (
        input  mode, sel, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_ch
    );
endinterface

// File: rtl/stream_mux_rr.sv
// N-channel valid/ready stream mux with a registered output stage.
// Channels are picked either by fixed select or by round-robin arbitration.
module stream_mux_rr #(
    parameter int unsigned N_CH  = 4,
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    stream_mux_rr_if.slave   bus
);
    localparam int unsigned SEL_W = (N_CH > 1) ? $clog2(N_CH) : 1;

    logic                load_en;
    logic                grant_vld;
    logic                fix_vld;
    logic                rr_vld;
    logic                xfer;
    logic [SEL_W-1:0]    gnt;
    logic [SEL_W-1:0]    rr_gnt;
    logic [SEL_W-1:0]    rr_ptr;
    logic [SEL_W-1:0]    rr_nxt;
    logic [WIDTH-1:0]    gnt_data;
    logic [N_CH-1:0]     ready;

    logic                valid_q;
    logic [WIDTH-1:0]    data_q;
    logic [SEL_W-1:0]    ch_q;

    // Output register may take a new beat when empty or being drained this cycle.
    assign load_en = !valid_q || bus.out_ready;

    // Fixed select: an index with no matching channel simply grants nothing.
    always_comb begin
        fix_vld = 1'b0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            if (bus.sel == SEL_W'(i)) begin
                fix_vld = bus.in_valid[i];
            end
        end
    end

    // Round-robin: first valid channel at or above rr_ptr, wrapping to 0.
    always_comb begin
        int unsigned      pos;
        logic [SEL_W-1:0] idx;
        rr_vld = 1'b0;
        rr_gnt = '0;
        pos    = 0;
        idx    = '0;
        for (int unsigned k = 0; k < N_CH; k++) begin
            pos = 32'(rr_ptr) + k;
            if (pos >= N_CH) begin
                pos = pos - N_CH;
            end
            idx = SEL_W'(pos);
            if (!rr_vld && bus.in_valid[idx]) begin
                rr_vld = 1'b1;
                rr_gnt = idx;
            end
        end
    end

    assign grant_vld = bus.mode ? rr_vld : fix_vld;
    assign gnt       = bus.mode ? rr_gnt : bus.sel;
    assign xfer      = !rst && load_en && grant_vld;
    assign rr_nxt    = (gnt == SEL_W'(N_CH - 1)) ? '0 : gnt + SEL_W'(1);

    // One-hot accept and data select for the granted channel.
    always_comb begin
        ready    = '0;
        gnt_data = '0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            if (gnt == SEL_W'(i)) begin
                ready[i] = xfer;
                gnt_data = bus.in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            ch_q    <= '0;
            rr_ptr  <= '0;
        end else begin
            if (load_en) begin
                if (grant_vld) begin
                    valid_q <= 1'b1;
                    data_q  <= gnt_data;
                    ch_q    <= gnt;
                end else begin
                    valid_q <= 1'b0;
                end
            end
            if (bus.mode && xfer) begin
                rr_ptr <= rr_nxt;
            end
        end
    end

    assign bus.in_ready  = ready;
    assign bus.out_valid = valid_q;
    assign bus.out_data  = data_q;
    assign bus.out_ch    = ch_q;
endmodule

// File: tb/tb_stream_mux_rr.sv
// Directed bench for stream_mux_rr: reset, fixed select, round-robin order,
// skip/wrap, backpressure and reset while a beat is held.
module tb_stream_mux_rr;
    localparam int unsigned N_CH  = 4;
    localparam int unsigned WIDTH = 8;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    stream_mux_rr_if #(.N_CH(N_CH), .WIDTH(WIDTH)) bus ();

    stream_mux_rr #(.N_CH(N_CH), .WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst          = 1'b1;
        bus.mode     = 1'b1;
        bus.sel      = 2'd0;
        bus.in_valid = 4'b1111;
        bus.in_data  = {8'h44, 8'h33, 8'h22, 8'h11};
        bus.out_ready = 1'b1;
        for (int c = 0; c < 2; c++) begin
            step();
            checks++;
            if (bus.in_ready !== 4'b0000) begin
                errors++;
                $display("FAIL reset_in_ready cyc %0d got %b exp 0000", c, bus.in_ready);
            end
        end
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_out_valid got %b exp 0", bus.out_valid);
        end
        checks++;
        if (bus.out_data !== 8'h00) begin
            errors++;
            $display("FAIL reset_out_data got %h exp 00", bus.out_data);
        end
        checks++;
        if (bus.out_ch !== 2'd0) begin
            errors++;
            $display("FAIL reset_out_ch got %0d exp 0", bus.out_ch);
        end
        checks++;
        if (dut.rr_ptr !== 2'd0) begin
            errors++;
            $display("FAIL reset_rr_ptr got %0d exp 0", dut.rr_ptr);
        end
        bus.in_valid = 4'b0000;
        rst = 1'b0;
        step();
    endtask

    task automatic test_fixed();
        logic [7:0] d;
        bus.mode      = 1'b0;
        bus.sel       = 2'd2;
        bus.in_valid  = 4'b1111;
        bus.in_data   = {8'h44, 8'hA5, 8'h22, 8'h11};
        bus.out_ready = 1'b1;
        #1;
        checks++;
        if (bus.in_ready !== 4'b0100) begin
            errors++;
            $display("FAIL fixed_in_ready got %b exp 0100", bus.in_ready);
        end
        for (int k = 0; k < 3; k++) begin
            d = 8'hA5 + 8'(k);
            bus.in_data = {8'h44, d, 8'h22, 8'h11};
            step();
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== d || bus.out_ch !== 2'd2) begin
                errors++;
                $display("FAIL fixed_beat %0d got v=%b d=%h ch=%0d exp v=1 d=%h ch=2",
                         k, bus.out_valid, bus.out_data, bus.out_ch, d);
            end
            checks++;
            if (bus.in_ready !== 4'b0100) begin
                errors++;
                $display("FAIL fixed_sustain_ready %0d got %b exp 0100", k, bus.in_ready);
            end
        end
        checks++;
        if (dut.rr_ptr !== 2'd0) begin
            errors++;
            $display("FAIL fixed_rr_ptr got %0d exp 0", dut.rr_ptr);
        end
        bus.in_valid = 4'b0000;
        step();
        checks++;
        if (bus.out_valid !== 1'b0 || bus.out_data !== 8'hA7 || bus.out_ch !== 2'd2) begin
            errors++;
            $display("FAIL fixed_drain got v=%b d=%h ch=%0d exp v=0 d=a7 ch=2",
                     bus.out_valid, bus.out_data, bus.out_ch);
        end
    endtask

    task automatic test_rr_fair();
        bus.mode      = 1'b1;
        bus.in_valid  = 4'b1111;
        bus.in_data   = {8'h13, 8'h12, 8'h11, 8'h10};
        bus.out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            step();
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out_ch !== 2'(k % 4) ||
                bus.out_data !== 8'(8'h10 + k % 4)) begin
                errors++;
                $display("FAIL rr_seq %0d got v=%b ch=%0d d=%h exp v=1 ch=%0d d=%h",
                         k, bus.out_valid, bus.out_ch, bus.out_data, k % 4, 8'h10 + k % 4);
            end
        end
        checks++;
        if (dut.rr_ptr !== 2'd0) begin
            errors++;
            $display("FAIL rr_ptr_after_fair got %0d exp 0", dut.rr_ptr);
        end
    endtask

    task automatic test_rr_skip_wrap();
        bus.mode     = 1'b1;
        bus.in_data  = {8'h13, 8'h12, 8'h11, 8'h10};
        bus.in_valid = 4'b0100;
        step();
        checks++;
        if (bus.out_ch !== 2'd2 || dut.rr_ptr !== 2'd3) begin
            errors++;
            $display("FAIL rr_setup got ch=%0d ptr=%0d exp ch=2 ptr=3", bus.out_ch, dut.rr_ptr);
        end
        bus.in_valid = 4'b0010;
        #1;
        checks++;
        if (bus.in_ready !== 4'b0010) begin
            errors++;
            $display("FAIL rr_skip_ready got %b exp 0010", bus.in_ready);
        end
        step();
        checks++;
        if (bus.out_ch !== 2'd1 || bus.out_data !== 8'h11 || dut.rr_ptr !== 2'd2) begin
            errors++;
            $display("FAIL rr_skip got ch=%0d d=%h ptr=%0d exp ch=1 d=11 ptr=2",
                     bus.out_ch, bus.out_data, dut.rr_ptr);
        end
        bus.in_valid = 4'b0001;
        step();
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_ch !== 2'd0 || bus.out_data !== 8'h10 ||
            dut.rr_ptr !== 2'd1) begin
            errors++;
            $display("FAIL rr_wrap got v=%b ch=%0d d=%h ptr=%0d exp v=1 ch=0 d=10 ptr=1",
                     bus.out_valid, bus.out_ch, bus.out_data, dut.rr_ptr);
        end
        bus.in_valid = 4'b0000;
        step();
    endtask

    task automatic test_backpressure();
        bus.mode      = 1'b0;
        bus.sel       = 2'd3;
        bus.in_valid  = 4'b1000;
        bus.in_data   = {8'h33, 8'h02, 8'h01, 8'h00};
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        bus.in_valid  = 4'b1111;
        bus.in_data   = {8'h44, 8'h02, 8'h01, 8'h00};
        for (int c = 0; c < 5; c++) begin
            #1;
            checks++;
            if (bus.in_ready !== 4'b0000) begin
                errors++;
                $display("FAIL bp_in_ready %0d got %b exp 0000", c, bus.in_ready);
            end
            step();
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h33 || bus.out_ch !== 2'd3) begin
                errors++;
                $display("FAIL bp_hold %0d got v=%b d=%h ch=%0d exp v=1 d=33 ch=3",
                         c, bus.out_valid, bus.out_data, bus.out_ch);
            end
        end
        bus.out_ready = 1'b1;
        #1;
        checks++;
        if (bus.in_ready !== 4'b1000) begin
            errors++;
            $display("FAIL bp_release_ready got %b exp 1000", bus.in_ready);
        end
        step();
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h44 || bus.out_ch !== 2'd3) begin
            errors++;
            $display("FAIL bp_next_beat got v=%b d=%h ch=%0d exp v=1 d=44 ch=3",
                     bus.out_valid, bus.out_data, bus.out_ch);
        end
        bus.in_valid = 4'b0000;
        step();
    endtask

    task automatic test_reset_mid();
        bus.mode      = 1'b1;
        bus.in_valid  = 4'b0010;
        bus.in_data   = {8'h13, 8'h12, 8'h55, 8'h10};
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        step();
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h55 || dut.rr_ptr !== 2'd2) begin
            errors++;
            $display("FAIL mid_held got v=%b d=%h ptr=%0d exp v=1 d=55 ptr=2",
                     bus.out_valid, bus.out_data, dut.rr_ptr);
        end
        rst = 1'b1;
        step();
        checks++;
        if (bus.out_valid !== 1'b0 || dut.rr_ptr !== 2'd0 || bus.in_ready !== 4'b0000) begin
            errors++;
            $display("FAIL mid_reset got v=%b ptr=%0d rdy=%b exp v=0 ptr=0 rdy=0000",
                     bus.out_valid, dut.rr_ptr, bus.in_ready);
        end
        rst           = 1'b0;
        bus.in_valid  = 4'b1111;
        bus.in_data   = {8'h13, 8'h12, 8'h11, 8'h10};
        bus.out_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            step();
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out_ch !== 2'(k)) begin
                errors++;
                $display("FAIL mid_restart %0d got v=%b ch=%0d exp v=1 ch=%0d",
                         k, bus.out_valid, bus.out_ch, k);
            end
        end
        bus.in_valid = 4'b0000;
        step();
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        rst           = 1'b1;
        bus.mode      = 1'b0;
        bus.sel       = '0;
        bus.in_valid  = '0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        test_reset();
        test_fixed();
        test_rr_fair();
        test_rr_skip_wrap();
        test_backpressure();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
